// File: rtl/seg_scan_display_pkg.sv
// seg_pkg: shared constants and helpers for the seven-segment scan driver.
// Segment patterns are active-low, segments a..g on bits 0..6.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // All anodes released; sliced down to the digit count in use (max 8).
   localparam logic [7:0] SEG_AN_OFF = 8'hFF;

   // Counter width able to hold 0..n-1 (never less than one bit).
   function automatic int seg_cnt_width(input int n);
      int w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: value/brightness inputs and display pin outputs of
// the scanner. The application side uses master, the scanner uses slave.
interface seg_scan_display_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] number;
   logic [NUM_DIGITS-1:0]   dp;
   logic [3:0]              bright;
   logic [NUM_DIGITS-1:0]   an;
   logic [6:0]              seg;
   logic                    dp_n;
   logic                    frame;

   modport master (output number, dp, bright, input an, seg, dp_n, frame);
   modport slave  (input number, dp, bright, output an, seg, dp_n, frame);
endinterface

// File: rtl/seg_scan_display_hex7seg.sv
// hex7seg: combinational 4-bit hex to active-low seven-segment decoder.
module hex7seg
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   // Full 0-F decode: 0-9, A, b, C, d, E, F
   always_comb begin
      seg = SEG_BLANK;
      case (hex)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed common-anode seven-segment scanner
// with per-frame input snapshot and 16-level PWM brightness.
// Build macro: SEG_LZB_EN enables leading-zero blanking.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 65536
) (
   input logic               clk,
   input logic               rst,
   seg_scan_display_if.slave bus
);

   localparam int PW     = seg_cnt_width(REFRESH_DIV);
   localparam int PH_LEN = REFRESH_DIV / 16;
   localparam int SW     = seg_cnt_width(PH_LEN);
   localparam int IW     = seg_cnt_width(NUM_DIGITS);

   localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [SW-1:0] SUB_MAX  = SW'(PH_LEN - 1);
   localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           pcnt_p0;
   logic [SW-1:0]           sub_p0;
   logic [3:0]              phase_p0;
   logic [IW-1:0]           idx_p0;
   logic                    run_p0;
   logic [4*NUM_DIGITS-1:0] num_sh;
   logic [NUM_DIGITS-1:0]   dp_sh;
   logic [3:0]              bright_sh;

   logic                    tick;
   logic                    wrap;
   logic [3:0]              nib;
   logic                    dp_sel;
   logic [6:0]              seg_dec;
   logic                    blank;
   logic                    active;

   logic [NUM_DIGITS-1:0]   an_p1;
   logic [6:0]              seg_p1;
   logic                    dp_n_p1;
   logic                    frame_p1;

   assign tick = (pcnt_p0 == PCNT_MAX);
   // The slot right after reset is a dark lead-in, so its tick also starts
   // a frame: the first frame begins one slot after reset is released.
   assign wrap = !run_p0 || (idx_p0 == IDX_MAX);

   // ---- stage p0: prescaler, PWM phase, digit index and frame snapshot ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         pcnt_p0   <= '0;
         sub_p0    <= '0;
         phase_p0  <= '0;
         idx_p0    <= '0;
         run_p0    <= 1'b0;
         num_sh    <= '0;
         dp_sh     <= '0;
         bright_sh <= '0;
      end else if (tick) begin
         pcnt_p0  <= '0;
         sub_p0   <= '0;
         phase_p0 <= '0;
         run_p0   <= 1'b1;
         if (wrap) begin
            idx_p0    <= '0;
            num_sh    <= bus.number;
            dp_sh     <= bus.dp;
            bright_sh <= bus.bright;
         end else begin
            idx_p0 <= idx_p0 + 1'b1;
         end
      end else begin
         pcnt_p0 <= pcnt_p0 + 1'b1;
         if (sub_p0 == SUB_MAX) begin
            sub_p0   <= '0;
            phase_p0 <= phase_p0 + 1'b1;
         end else begin
            sub_p0 <= sub_p0 + 1'b1;
         end
      end
   end

   // Select the nibble and decimal point of the digit being scanned
   always_comb begin
      nib    = 4'h0;
      dp_sel = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_p0 == IW'(k)) begin
            nib    = num_sh[4*k +: 4];
            dp_sel = dp_sh[k];
         end
      end
   end

   hex7seg u_hex7seg (
      .hex (nib),
      .seg (seg_dec)
   );

`ifdef SEG_LZB_EN
   // Blank digit k > 0 while it and every higher digit are zero with no
   // decimal point lit; a lit point makes the zeros below it significant.
   always_comb begin
      logic lead;
      lead  = 1'b1;
      blank = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         lead = lead && (num_sh[4*k +: 4] == 4'h0) && !dp_sh[k];
         if (idx_p0 == IW'(k)) blank = lead;
      end
   end
`else
   assign blank = 1'b0;
`endif

   // The tick cycle is forced dark so each slot starts with one anode-off clock
   assign active = run_p0 && !tick && (phase_p0 <= bright_sh) && !blank;

   // ---- stage p1: registered display pins ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         an_p1    <= SEG_AN_OFF[NUM_DIGITS-1:0];
         seg_p1   <= SEG_BLANK;
         dp_n_p1  <= 1'b1;
         frame_p1 <= 1'b0;
      end else begin
         frame_p1 <= tick && wrap;
         if (active) begin
            an_p1   <= ~(NUM_DIGITS'(1) << idx_p0);
            seg_p1  <= seg_dec;
            dp_n_p1 <= ~dp_sel;
         end else begin
            an_p1   <= SEG_AN_OFF[NUM_DIGITS-1:0];
            seg_p1  <= SEG_BLANK;
            dp_n_p1 <= 1'b1;
         end
      end
   end

   assign bus.an    = an_p1;
   assign bus.seg   = seg_p1;
   assign bus.dp_n  = dp_n_p1;
   assign bus.frame = frame_p1;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: table-driven, scoreboarded bench for seg_scan_display
// with NUM_DIGITS=4 and REFRESH_DIV=32 (128-clock frames).
module tb_seg_scan_display;

   localparam int ND = 4;
   localparam int RD = 32;
   localparam int FRAME = ND * RD;
   localparam int NV = 10;

`ifdef SEG_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   typedef struct {
      logic [15:0] number;
      logic [3:0]  dp;
      logic [3:0]  bright;
      logic [27:0] exp_seg;   // {digit3, digit2, digit1, digit0} patterns
      logic [3:0]  exp_lit;   // digits expected to light at all
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   seg_scan_display_if #(.NUM_DIGITS(ND)) bus ();

   seg_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   rec_t vec[NV];
   rec_t sb[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Clocks lit per slot: pcnt 0..30 drive the visible cycles, phase = pcnt/2
   function automatic int on_model(input logic [3:0] b);
      int n = 0;
      for (int p = 0; p < RD - 1; p++) if ((p / 2) <= int'(b)) n++;
      return n;
   endfunction

   task automatic drive(input rec_t r);
      bus.number = r.number;
      bus.dp     = r.dp;
      bus.bright = r.bright;
   endtask

   // Reset, load r as the first snapshot, and wait for the first frame pulse
   task automatic reset_seq(input rec_t r);
      int n, lead_bad;
      bit found;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_an_next_edge", int'(bus.an), 4'hF);
      repeat (4) @(negedge clk);
      chk("rst_an", int'(bus.an), 4'hF);
      chk("rst_seg", int'(bus.seg), 7'h7F);
      chk("rst_dp_n", int'(bus.dp_n), 1);
      chk("rst_frame", int'(bus.frame), 0);
      drive(r);
      sb.push_back(r);
      rst = 1'b1;
      n = 0; lead_bad = 0; found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         n++;
         if (bus.frame) found = 1'b1;
         else if (bus.an != 4'hF) lead_bad++;
      end
      chk("first_frame_latency", n, RD);
      chk("leadin_dark", lead_bad, 0);
   endtask

   // Observe one frame starting at the frame-pulse cycle; optionally drive
   // the next vector mid-frame, then compare against the scoreboard head.
   task automatic capture_frame(input int next_idx);
      int   on[ND], dpc[ND], segv[ND];
      bit   seen[ND];
      int   frame_bad, gap_bad, dark_bad, wrong_an, segvar, on_exp;
      logic [3:0] want;
      rec_t e;
      frame_bad = 0; gap_bad = 0; dark_bad = 0; wrong_an = 0; segvar = 0;
      for (int d = 0; d < ND; d++) begin on[d] = 0; dpc[d] = 0; segv[d] = 0; seen[d] = 0; end
      for (int c = 0; c < FRAME; c++) begin
         int s, pos;
         if (c > 0) @(negedge clk);
         s = c / RD;
         pos = c % RD;
         want = ~(4'b0001 << s);
         if (bus.frame != (c == 0)) frame_bad++;
         if (pos == 0 && bus.an != 4'hF) gap_bad++;
         if (bus.an == 4'hF) begin
            if (bus.seg != 7'h7F || bus.dp_n != 1'b1) dark_bad++;
         end else if (bus.an == want) begin
            on[s]++;
            if (!seen[s]) begin seen[s] = 1'b1; segv[s] = int'(bus.seg); end
            else if (int'(bus.seg) != segv[s]) segvar++;
            if (!bus.dp_n) dpc[s]++;
         end else begin
            wrong_an++;
         end
         if (c == 50 && next_idx >= 0) begin
            drive(vec[next_idx]);
            sb.push_back(vec[next_idx]);
         end
      end
      e = sb.pop_front();
      on_exp = on_model(e.bright);
      chk("frame_pulse_shape", frame_bad, 0);
      chk("dead_time_gap", gap_bad, 0);
      chk("dark_outputs", dark_bad, 0);
      chk("anode_order", wrong_an, 0);
      chk("seg_stable_in_frame", segvar, 0);
      for (int d = 0; d < ND; d++) begin
         logic [27:0] es;
         es = e.exp_seg;
         chk($sformatf("on_clocks_d%0d_n%04h", d, e.number), on[d], e.exp_lit[d] ? on_exp : 0);
         if (e.exp_lit[d])
            chk($sformatf("seg_d%0d_n%04h", d, e.number), segv[d], int'(es[7*d +: 7]));
         chk($sformatf("dp_clocks_d%0d_n%04h", d, e.number), dpc[d],
             (e.exp_lit[d] && e.dp[d]) ? on_exp : 0);
      end
   endtask

   initial begin
      vec[0] = '{16'h1234, 4'b0000, 4'd15, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
      vec[1] = '{16'hABCD, 4'b0000, 4'd15, {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF};
      vec[2] = '{16'h0F00, 4'b0000, 4'd15, {7'h40, 7'h0E, 7'h40, 7'h40},
                 LZB ? 4'b0111 : 4'hF};
      vec[3] = '{16'h5678, 4'b0100, 4'd0,  {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF};
      vec[4] = '{16'h9E0F, 4'b0000, 4'd7,  {7'h10, 7'h06, 7'h40, 7'h0E}, 4'hF};
      vec[5] = '{16'h0005, 4'b0000, 4'd15, {7'h40, 7'h40, 7'h40, 7'h12},
                 LZB ? 4'b0001 : 4'hF};
      vec[6] = '{16'h0000, 4'b0000, 4'd3,  {7'h40, 7'h40, 7'h40, 7'h40},
                 LZB ? 4'b0001 : 4'hF};
      vec[7] = '{16'h0005, 4'b1000, 4'd15, {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF};
      vec[8] = '{16'hF1A0, 4'b0001, 4'd1,  {7'h0E, 7'h79, 7'h08, 7'h40}, 4'hF};
      vec[9] = '{16'hC0DE, 4'b1010, 4'd15, {7'h46, 7'h40, 7'h21, 7'h06}, 4'hF};

      drive(vec[0]);
      reset_seq(vec[0]);

      // Each frame also receives the next vector mid-frame (snapshot coherence)
      for (int i = 0; i < NV; i++) begin
         capture_frame((i + 1 < NV) ? i + 1 : -1);
         @(negedge clk);
         chk("frame_period", int'(bus.frame), 1);
      end

      // Reset in the middle of a lit slot, then restart scanning
      repeat (45) @(negedge clk);
      chk("midscan_lit_before_reset", int'(bus.an), 4'b1101);
      reset_seq(vec[3]);
      capture_frame(-1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
